// File: rtl/usb_tx_pkg.sv
// USB full-speed TX encoder shared types: FSM states and line symbols.
// USB_TX_SYNC_GEN_EN adds the SYNC generation state.
package usb_tx_pkg;

`ifdef USB_TX_SYNC_GEN_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SE0A,
    ST_SE0B,
    ST_EOPJ,
    ST_SYNC
  } tx_state_t;

  // NRZI source bits of SYNC, LSB first: KJKJKJKK
  localparam logic [7:0] SYNC_BYTE = 8'h80;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SE0A,
    ST_SE0B,
    ST_EOPJ
  } tx_state_t;
`endif

  // {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Wrapping bit-period counter; boundary marks the last cycle of a period.
module usb_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic en,
  output logic boundary
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] MAX = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = MAX;
    end else if (en) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign boundary = (cnt_q == MAX);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB FS TX line encoder: bit stuffing, NRZI, EOP, PtS pacing.
// USB_TX_SYNC_GEN_EN: emit SYNC (KJKJKJKK) before the first data bit.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_start,
  input  logic serial_in,
  input  logic eop_req,
  output logic bit_strobe,
  output logic dplus_out,
  output logic dminus_out,
  output logic busy,
  output logic eop_done
);

  import usb_tx_pkg::*;

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);

  tx_state_t state_q;
  tx_state_t state_d;
  logic level_q;
  logic level_d;
  logic [OW-1:0] ones_q;
  logic [OW-1:0] ones_d;
  logic [1:0] line_q;
  logic [1:0] line_d;
  logic strobe_q;
  logic strobe_d;
  logic done_q;
  logic done_d;
  logic consume;
  logic bnd;
  logic timer_load;
  logic timer_en;
`ifdef USB_TX_SYNC_GEN_EN
  logic [2:0] sync_q;
  logic [2:0] sync_d;
`endif

  assign timer_load = (state_q == ST_IDLE) && tx_start;
  assign timer_en   = (state_q != ST_IDLE);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (timer_load),
    .en      (timer_en),
    .boundary(bnd)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      level_q  <= 1'b1;
      ones_q   <= '0;
      line_q   <= LINE_J;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
      sync_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ones_q   <= ones_d;
      line_q   <= line_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
`ifdef USB_TX_SYNC_GEN_EN
      sync_q   <= sync_d;
`endif
    end
  end

  // level_q is the NRZI line level: 1 = J, 0 = K
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ones_d  = ones_q;
    consume = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
    sync_d  = sync_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          ones_d  = '0;
          level_d = 1'b1;
`ifdef USB_TX_SYNC_GEN_EN
          sync_d  = '0;
          state_d = ST_SYNC;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef USB_TX_SYNC_GEN_EN
      ST_SYNC: begin
        if (bnd) begin
          sync_d = sync_q + 3'd1;
          if (SYNC_BYTE[sync_q]) begin
            ones_d  = OW'(1);
            state_d = ST_DATA;
          end else begin
            level_d = ~level_q;
          end
        end
      end
`endif
      ST_DATA: begin
        if (bnd) begin
          if (ones_q == STUFF_MAX) begin
            level_d = ~level_q;
            ones_d  = '0;
          end else if (eop_req) begin
            state_d = ST_SE0A;
          end else begin
            consume = 1'b1;
            if (serial_in) begin
              ones_d = ones_q + OW'(1);
            end else begin
              level_d = ~level_q;
              ones_d  = '0;
            end
          end
        end
      end
      ST_SE0A: begin
        if (bnd) state_d = ST_SE0B;
      end
      ST_SE0B: begin
        if (bnd) begin
          state_d = ST_EOPJ;
          level_d = 1'b1;
        end
      end
      ST_EOPJ: begin
        if (bnd) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d   = line_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (bnd && (state_q != ST_IDLE)) begin
      strobe_d = consume;
      done_d   = (state_q == ST_EOPJ);
      unique case (1'b1)
        (state_d == ST_SE0A),
        (state_d == ST_SE0B): line_d = LINE_SE0;
        default:              line_d = level_d ? LINE_J : LINE_K;
      endcase
    end
  end

  assign dplus_out  = line_q[1];
  assign dminus_out = line_q[0];
  assign bit_strobe = strobe_q;
  assign eop_done   = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
